// File: rtl/calc_pkg.sv
// Shared constants, state encoding and key-decoding helpers for the calculator sequencer.
package calc_pkg;

  localparam int OPW  = 7;
  localparam int RESW = 14;

  localparam logic [3:0] KEY_CLR = 4'd10;
  localparam logic [3:0] KEY_EQ  = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_D   = 4'd15;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_WAIT, S_SHOW} state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k >= KEY_ADD) && (k <= KEY_MUL);
  endfunction

  // Operator keys are contiguous, so the op code is the offset from KEY_ADD.
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    logic [3:0] d;
    d = k - KEY_ADD;
    return d[1:0];
  endfunction

endpackage

// File: rtl/calc_sequencer_dec_entry.sv
// dec_entry: decimal digit accumulator for one operand; clear+load together restarts with one digit.
module dec_entry
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 2,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_load,
  input  logic [3:0]     i_digit,
  output logic [OPW-1:0] o_value,
  output logic [CW-1:0]  o_count
);

  logic [OPW-1:0] r_value;
  logic [CW-1:0]  r_count;
  logic [OPW-1:0] w_mac;
  logic           w_room;

  assign w_mac  = r_value * OPW'(10) + OPW'(i_digit);
  assign w_room = (r_count < CW'(MAX_DIGITS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clear && i_load) begin
      r_value <= OPW'(i_digit);
      r_count <= CW'(1);
    end else if (i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load && w_room) begin
      r_value <= w_mac;
      r_count <= r_count + CW'(1);
    end
  end

  assign o_value = r_value;
  assign o_count = r_count;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-to-ALU sequencer: collects operands/operator, runs the ALU handshake, latches the result.
// Optional ALU timeout is enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS  = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  output logic            alu_start,
  output logic [1:0]      alu_op,
  output logic [OPW-1:0]  alu_a,
  output logic [OPW-1:0]  alu_b,
  input  logic            alu_done,
  input  logic [RESW-1:0] alu_result,
  input  logic            alu_neg,
  output logic [RESW-1:0] result,
  output logic            result_neg,
  output logic            res_valid,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t          r_state, w_next;
  logic            r_start, r_busy, r_neg, r_rv;
  logic [1:0]      r_op;
  logic [RESW-1:0] r_result;
  logic [CW-1:0]   w_cnt_a, w_cnt_b;
  logic            w_clr_a, w_ld_a, w_clr_b, w_ld_b;
  logic            w_op_we, w_full_clr, w_take_res, w_rv_clr;
  logic            w_dig, w_op, w_eq, w_clr;
  logic            w_tmo_hit;

  assign w_dig = key_valid && is_digit(key_code);
  assign w_op  = key_valid && is_op(key_code);
  assign w_eq  = key_valid && (key_code == KEY_EQ);
  assign w_clr = key_valid && (key_code == KEY_CLR);

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  // Counts completed S_WAIT cycles; restarts from zero on every entry.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != S_WAIT)) r_tmo <= '0;
    else                               r_tmo <= r_tmo + TW'(1);
  end

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                                                      r_err <= 1'b0;
    else if (r_state == S_WAIT && w_tmo_hit && !alu_done)            r_err <= 1'b1;
    else if (key_valid && r_state != S_EXEC && r_state != S_WAIT)    r_err <= 1'b0;
  end

  assign err = r_err;
`else
  assign w_tmo_hit = 1'b0;
  // No timeout in this build; err is a constant 0.
  assign err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_A;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_clr_a    = 1'b0;
    w_ld_a     = 1'b0;
    w_clr_b    = 1'b0;
    w_ld_b     = 1'b0;
    w_op_we    = 1'b0;
    w_full_clr = 1'b0;
    w_take_res = 1'b0;
    w_rv_clr   = 1'b0;
    case (r_state)
      S_A: begin
        if (w_clr) w_full_clr = 1'b1;
        else if (w_dig) w_ld_a = 1'b1;
        else if (w_op && w_cnt_a != '0) begin
          w_op_we = 1'b1;
          w_next  = S_B;
        end
      end
      S_B: begin
        if (w_clr) w_full_clr = 1'b1;
        else if (w_dig) w_ld_b = 1'b1;
        else if (w_op && w_cnt_b == '0) w_op_we = 1'b1;
        else if (w_eq && w_cnt_b != '0) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_WAIT;
      S_WAIT: begin
        // Done wins over both a coincident key and an expiring timeout.
        if (alu_done) begin
          w_take_res = 1'b1;
          w_next     = S_SHOW;
        end else if (w_tmo_hit) begin
          w_clr_a = 1'b1;
          w_clr_b = 1'b1;
          w_next  = S_A;
        end
      end
      S_SHOW: begin
        if (w_clr) w_full_clr = 1'b1;
        else if (w_dig) begin
          w_clr_a  = 1'b1;
          w_ld_a   = 1'b1;
          w_clr_b  = 1'b1;
          w_rv_clr = 1'b1;
          w_next   = S_A;
        end
      end
      default: w_next = S_A;
    endcase
    if (w_full_clr) begin
      w_clr_a = 1'b1;
      w_clr_b = 1'b1;
      w_next  = S_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_op     <= OP_SUM;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_rv     <= 1'b0;
    end else begin
      r_start <= (r_state == S_EXEC);
      r_busy  <= (w_next == S_EXEC) || (w_next == S_WAIT);
      if (w_full_clr) begin
        r_op     <= OP_SUM;
        r_result <= '0;
        r_neg    <= 1'b0;
        r_rv     <= 1'b0;
      end else begin
        if (w_op_we) r_op <= key_to_op(key_code);
        if (w_take_res) begin
          r_result <= alu_result;
          r_neg    <= alu_neg;
          r_rv     <= 1'b1;
        end else if (w_rv_clr) begin
          r_rv <= 1'b0;
        end
      end
    end
  end

  dec_entry #(.MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_ent_a (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clr_a), .i_load(w_ld_a),
    .i_digit(key_code), .o_value(alu_a), .o_count(w_cnt_a)
  );

  dec_entry #(.MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_ent_b (
    .clk(clk), .rst_n(rst_n), .i_clear(w_clr_b), .i_load(w_ld_b),
    .i_digit(key_code), .o_value(alu_b), .o_count(w_cnt_b)
  );

  assign alu_start  = r_start;
  assign alu_op     = r_op;
  assign result     = r_result;
  assign result_neg = r_neg;
  assign res_valid  = r_rv;
  assign busy       = r_busy;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed scenarios plus randomized keys against a key-level model.
module tb_calc_sequencer;

  localparam int TMO = 64;
  localparam int M_A = 0, M_B = 1, M_EXEC = 2, M_WAIT = 3, M_SHOW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [6:0]  alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [13:0] alu_result = 14'd0;
  logic        alu_neg = 1'b0;
  logic [13:0] result;
  logic        result_neg, res_valid, busy, err;

  int errors = 0;
  int checks = 0;

  int m_a, m_b, m_na, m_nb, m_op, m_res, m_neg, m_rv, m_err, m_mode;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_neg(alu_neg),
    .result(result), .result_neg(result_neg), .res_valid(res_valid),
    .busy(busy), .err(err)
  );

  logic [33:0] w_dut;
  assign w_dut = {alu_a, alu_b, alu_op, result, result_neg, res_valid, busy, err};

  function automatic void m_clear();
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
    m_res = 0; m_neg = 0; m_rv = 0; m_err = 0; m_mode = M_A;
  endfunction

  function automatic void m_key(input int k);
    if (m_mode == M_EXEC || m_mode == M_WAIT) return;
    m_err = 0;
    if (k == 10) begin
      m_clear();
    end else if (k <= 9) begin
      if (m_mode == M_SHOW) begin
        m_a = k; m_na = 1; m_b = 0; m_nb = 0; m_rv = 0; m_mode = M_A;
      end else if (m_mode == M_A) begin
        if (m_na < 2) begin m_a = m_a * 10 + k; m_na++; end
      end else begin
        if (m_nb < 2) begin m_b = m_b * 10 + k; m_nb++; end
      end
    end else if (k >= 12 && k <= 14) begin
      if (m_mode == M_A && m_na > 0) begin m_op = k - 12; m_mode = M_B; end
      else if (m_mode == M_B && m_nb == 0) m_op = k - 12;
    end else if (k == 11) begin
      if (m_mode == M_B && m_nb > 0) m_mode = M_EXEC;
    end
  endfunction

  function automatic logic [33:0] m_vec();
    return {7'(m_a), 7'(m_b), 2'(m_op), 14'(m_res), 1'(m_neg), 1'(m_rv),
            1'(m_mode == M_EXEC || m_mode == M_WAIT), 1'(m_err)};
  endfunction

  task automatic press(input int k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(k);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Called at a negedge: done is sampled on the next rising edge.
  task automatic pulse_done(input int r, input int n);
    alu_done   = 1'b1;
    alu_result = 14'(r);
    alu_neg    = 1'(n);
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (alu_start === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({w_dut, alu_start} !== 35'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", {w_dut, alu_start});
    end
    rst_n = 1'b1;
    m_clear();
  endtask

  task automatic test_add();
    int lat;
    press(1); press(2); press(12); press(3); press(4);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {7'd12, 7'd34, 2'd0}) begin
      errors++; $display("FAIL add_operands: got a=%0d b=%0d op=%0d expected 12 34 0", alu_a, alu_b, alu_op);
    end
    press(11);
    checks++;
    if (alu_start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL add_exec_edge: got start=%b busy=%b expected 0 1", alu_start, busy);
    end
    @(negedge clk);
    checks++;
    if (alu_start !== 1'b1) begin
      errors++; $display("FAIL add_start_latency: got %b expected 1", alu_start);
    end
    @(negedge clk);
    checks++;
    if (alu_start !== 1'b0) begin
      errors++; $display("FAIL add_start_width: got %b expected 0", alu_start);
    end
    pulse_done(46, 0);
    checks++;
    if ({result, result_neg, res_valid, busy} !== {14'd46, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_result: got %0d neg=%b rv=%b busy=%b expected 46 0 1 0",
                         result, result_neg, res_valid, busy);
    end
    lat = 0;
  endtask

  task automatic test_sub();
    int lat;
    press(7); press(13); press(9);
    checks++;
    if ({alu_a, alu_b, alu_op, res_valid} !== {7'd7, 7'd9, 2'd1, 1'b0}) begin
      errors++; $display("FAIL sub_operands: got a=%0d b=%0d op=%0d rv=%b expected 7 9 1 0",
                         alu_a, alu_b, alu_op, res_valid);
    end
    press(11);
    wait_start(lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL sub_start_latency: got %0d expected 1", lat);
    end
    pulse_done(2, 1);
    checks++;
    if ({result, result_neg, res_valid} !== {14'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sub_result: got %0d neg=%b rv=%b expected 2 1 1", result, result_neg, res_valid);
    end
  endtask

  task automatic test_mul_drop();
    int lat;
    press(9); press(9); press(9); press(14); press(9); press(9); press(9);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {7'd99, 7'd99, 2'd2}) begin
      errors++; $display("FAIL mul_digit_drop: got a=%0d b=%0d op=%0d expected 99 99 2", alu_a, alu_b, alu_op);
    end
    press(11);
    wait_start(lat);
    pulse_done(9801, 0);
    checks++;
    if ({result, result_neg, res_valid} !== {14'd9801, 1'b0, 1'b1}) begin
      errors++; $display("FAIL mul_result: got %0d neg=%b rv=%b expected 9801 0 1", result, result_neg, res_valid);
    end
  endtask

  task automatic test_clear();
    bit seen;
    press(10);
    checks++;
    if (w_dut !== 34'd0) begin
      errors++; $display("FAIL clear_from_show: got %h expected 0", w_dut);
    end
    press(5); press(12); press(13);
    checks++;
    if (alu_op !== 2'd1) begin
      errors++; $display("FAIL op_replace: got %0d expected 1", alu_op);
    end
    press(3); press(12);
    checks++;
    if ({alu_b, alu_op} !== {7'd3, 2'd1}) begin
      errors++; $display("FAIL op_locked_after_b: got b=%0d op=%0d expected 3 1", alu_b, alu_op);
    end
    press(10);
    checks++;
    if (w_dut !== 34'd0) begin
      errors++; $display("FAIL clear_in_b: got %h expected 0", w_dut);
    end
    press(11);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (alu_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL eq_after_clear: got start/busy activity expected none");
    end
    press(13); press(4);
    checks++;
    if ({alu_a, alu_b, alu_op} !== {7'd4, 7'd0, 2'd0}) begin
      errors++; $display("FAIL op_without_a: got a=%0d b=%0d op=%0d expected 4 0 0", alu_a, alu_b, alu_op);
    end
    press(10);
  endtask

  task automatic test_collision();
    int lat;
    press(1); press(12); press(1); press(11);
    wait_start(lat);
    key_valid = 1'b1; key_code = 4'd4;
    pulse_done(8, 0);
    key_valid = 1'b0;
    checks++;
    if ({result, res_valid, alu_a, busy} !== {14'd8, 1'b1, 7'd1, 1'b0}) begin
      errors++; $display("FAIL done_beats_key: got res=%0d rv=%b a=%0d busy=%b expected 8 1 1 0",
                         result, res_valid, alu_a, busy);
    end
    press(6);
    checks++;
    if ({res_valid, alu_a, alu_b} !== {1'b0, 7'd6, 7'd0}) begin
      errors++; $display("FAIL show_digit: got rv=%b a=%0d b=%0d expected 0 6 0", res_valid, alu_a, alu_b);
    end
    press(7); press(8);
    checks++;
    if (alu_a !== 7'd67) begin
      errors++; $display("FAIL show_restart_count: got %0d expected 67", alu_a);
    end
    @(negedge clk);
    pulse_done(123, 1);
    checks++;
    if ({result, result_neg, res_valid, busy} !== {14'd8, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL stray_done: got res=%0d neg=%b rv=%b busy=%b expected 8 0 0 0",
                         result, result_neg, res_valid, busy);
    end
    press(10);
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    bit seen;
    press(3); press(12); press(4); press(11);
    wait_start(lat);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_done(7, 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (alu_start !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (w_dut !== 34'd0 || seen !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait: got %h start_seen=%b expected 0 0", w_dut, seen);
    end
    press(3);
    checks++;
    if (alu_a !== 7'd3) begin
      errors++; $display("FAIL reset_mid_wait_state: got a=%0d expected 3", alu_a);
    end
    press(10);
  endtask

  task automatic test_timeout();
    int lat;
    press(2); press(12); press(3); press(11);
    wait_start(lat);
`ifdef CALC_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++; $display("FAIL timeout_early: got err=%b busy=%b expected 0 1", err, busy);
    end
    @(negedge clk);
    checks++;
    if ({err, busy, res_valid, alu_a, alu_b} !== {1'b1, 1'b0, 1'b0, 7'd0, 7'd0}) begin
      errors++; $display("FAIL timeout_expire: got err=%b busy=%b rv=%b a=%0d b=%0d expected 1 0 0 0 0",
                         err, busy, res_valid, alu_a, alu_b);
    end
    press(5);
    checks++;
    if ({err, alu_a} !== {1'b0, 7'd5}) begin
      errors++; $display("FAIL timeout_err_clear: got err=%b a=%0d expected 0 5", err, alu_a);
    end
    press(10);
    press(2); press(12); press(3); press(11);
    wait_start(lat);
    repeat (TMO - 1) @(negedge clk);
    pulse_done(6, 0);
    checks++;
    if ({err, res_valid, result} !== {1'b0, 1'b1, 14'd6}) begin
      errors++; $display("FAIL timeout_done_same_cycle: got err=%b rv=%b res=%0d expected 0 1 6",
                         err, res_valid, result);
    end
`else
    repeat (100) @(negedge clk);
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++; $display("FAIL wait_forever: got err=%b busy=%b expected 0 1", err, busy);
    end
    pulse_done(6, 0);
    checks++;
    if ({err, res_valid, result} !== {1'b0, 1'b1, 14'd6}) begin
      errors++; $display("FAIL late_done: got err=%b rv=%b res=%0d expected 0 1 6", err, res_valid, result);
    end
`endif
    press(10);
  endtask

  task automatic test_random();
    int k, r, lat, d;
    press(10);
    m_clear();
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 75) k = $urandom_range(12, 14);
      else if (r < 88) k = 11;
      else if (r < 93) k = 15;
      else             k = 10;
      @(negedge clk);
      key_valid  = 1'b1;
      key_code   = 4'(k);
      alu_done   = ($urandom_range(0, 9) == 0);
      alu_result = 14'($urandom);
      alu_neg    = 1'($urandom);
      @(negedge clk);
      key_valid = 1'b0;
      alu_done  = 1'b0;
      m_key(k);
      checks++;
      if (w_dut !== m_vec()) begin
        errors++; $display("FAIL rand_key[%0d] key=%0d: got %h expected %h", it, k, w_dut, m_vec());
      end
      if (m_mode == M_EXEC) begin
        wait_start(lat);
        m_mode = M_WAIT;
        checks++;
        if (lat !== 1 || w_dut !== m_vec()) begin
          errors++; $display("FAIL rand_start[%0d]: got lat=%0d %h expected 1 %h", it, lat, w_dut, m_vec());
        end
        d = $urandom_range(0, 5);
        for (int c = 0; c < d; c++) begin
          key_valid = 1'($urandom);
          key_code  = 4'($urandom);
          @(negedge clk);
        end
        key_valid = 1'($urandom);
        key_code  = 4'($urandom);
        r = $urandom_range(0, 16383);
        k = $urandom_range(0, 1);
        pulse_done(r, k);
        key_valid = 1'b0;
        m_res = r; m_neg = k; m_rv = 1; m_mode = M_SHOW;
        checks++;
        if (w_dut !== m_vec()) begin
          errors++; $display("FAIL rand_done[%0d]: got %h expected %h", it, w_dut, m_vec());
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_drop();
    test_clear();
    test_collision();
    test_reset_mid_wait();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
